// File: rtl/wb_irq_ctrl_if.sv
// rtl/wb_irq_ctrl_if.sv - Wishbone slave bus bundle for the interrupt controller
// Purpose: groups the Wishbone classic signals between a bus master and wb_irq_ctrl.
// Signals:
//   adr_i  32  byte address (master -> slave)
//   dat_i  32  write data   (master -> slave)
//   sel_i   4  byte lanes   (master -> slave)
//   cyc_i   1  bus cycle    (master -> slave)
//   stb_i   1  strobe       (master -> slave)
//   we_i    1  write enable (master -> slave)
//   dat_o  32  read data    (slave -> master)
//   ack_o   1  acknowledge  (slave -> master)
interface wb_irq_ctrl_if;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output adr_i, dat_i, sel_i, cyc_i, stb_i, we_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  adr_i, dat_i, sel_i, cyc_i, stb_i, we_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/wb_irq_ctrl.sv
// rtl/wb_irq_ctrl.sv - Wishbone interrupt controller with edge/level capture and priority claim
// Purpose: latches per-source interrupts into PENDING, masks them with ENABLE and drives
//          one registered aggregate interrupt; CLAIM returns the lowest pending&enabled id.
// Ports:
//   clk_i   in   1     system clock, rising edge
//   rst_i   in   1     synchronous active-high reset
//   bus     slave      Wishbone slave bundle (adr/dat/sel/cyc/stb/we in, dat/ack out)
//   irq_i   in   NIRQ  source interrupts, synchronous to clk_i
//   irq_o   out  1     aggregated interrupt to the CPU
// Register map (byte offsets): 0x00 RAW, 0x04 PENDING (W1C), 0x08 ENABLE, 0x0C MODE, 0x10 CLAIM
module wb_irq_ctrl #(
  parameter int              NIRQ     = 4,
  parameter logic [NIRQ-1:0] RST_MODE = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_irq_ctrl_if.slave      bus,
  input  logic [NIRQ-1:0]   irq_i,
  output logic              irq_o
);

  localparam logic [2:0] OFF_RAW     = 3'd0;
  localparam logic [2:0] OFF_PENDING = 3'd1;
  localparam logic [2:0] OFF_ENABLE  = 3'd2;
  localparam logic [2:0] OFF_MODE    = 3'd3;
  localparam logic [2:0] OFF_CLAIM   = 3'd4;

  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] enable;
  logic [NIRQ-1:0] mode;
  logic [NIRQ-1:0] irq_q;

  logic            req;
  logic            wr;
  logic            rd;
  logic [2:0]      off;
  logic [31:0]     lane_mask;
  logic [31:0]     wbits;
  logic [NIRQ-1:0] wset;
  logic [NIRQ-1:0] wmask;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] pend_en;
  logic            claim_valid;
  logic [4:0]      claim_id;
  logic [NIRQ-1:0] claim_onehot;
  logic [NIRQ-1:0] clr;
  logic [NIRQ-1:0] pending_nxt;
  logic [31:0]     rdata;
  logic            unused_bits;

  // ack_o gates req so an access held on the bus is acked once, then idles a cycle.
  assign req = bus.cyc_i & bus.stb_i & ~bus.ack_o;
  assign wr  = req & bus.we_i;
  assign rd  = req & ~bus.we_i;
  assign off = bus.adr_i[4:2];

  assign lane_mask = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}}, {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};
  assign wbits     = bus.dat_i & lane_mask;
  assign wset      = wbits[NIRQ-1:0];
  assign wmask     = lane_mask[NIRQ-1:0];

  assign rise    = irq_i & ~irq_q;
  assign pend_en = pending & enable;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    claim_valid = 1'b0;
    claim_id    = 5'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend_en[i]) begin
        claim_valid = 1'b1;
        claim_id    = 5'(i);
      end
    end
  end

  assign claim_onehot = NIRQ'(1) << claim_id;

  always_comb begin
    clr = '0;
    if (wr && off == OFF_PENDING) begin
      clr = clr | wset;
    end
    if (rd && off == OFF_CLAIM && claim_valid) begin
      clr = clr | claim_onehot;
    end
  end

  // Edge bits: a rise in the same cycle as a clear keeps the bit set.
  // Level bits: follow irq_i, so clears have no lasting effect.
  assign pending_nxt = (mode & ((pending & ~clr) | rise)) | (~mode & irq_i);

  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_RAW:     rdata = {{(32-NIRQ){1'b0}}, irq_i};
      OFF_PENDING: rdata = {{(32-NIRQ){1'b0}}, pending};
      OFF_ENABLE:  rdata = {{(32-NIRQ){1'b0}}, enable};
      OFF_MODE:    rdata = {{(32-NIRQ){1'b0}}, mode};
      OFF_CLAIM:   rdata = claim_valid ? {1'b1, 26'd0, claim_id} : 32'd0;
      default:     rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.ack_o <= 1'b0;
      bus.dat_o <= 32'd0;
      irq_o     <= 1'b0;
      pending   <= '0;
      enable    <= '0;
      mode      <= RST_MODE;
      irq_q     <= '0;
    end else begin
      bus.ack_o <= req;
      bus.dat_o <= rd ? rdata : 32'd0;
      irq_q     <= irq_i;
      pending   <= pending_nxt;
      irq_o     <= |pend_en;
      if (wr && off == OFF_ENABLE) begin
        enable <= (enable & ~wmask) | wset;
      end
      if (wr && off == OFF_MODE) begin
        mode <= (mode & ~wmask) | wset;
      end
    end
  end

  assign unused_bits = ^{bus.adr_i[31:5], bus.adr_i[1:0], wbits[31:NIRQ], lane_mask[31:NIRQ]};

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb/tb_wb_irq_ctrl.sv - scoreboard testbench for wb_irq_ctrl
module tb_wb_irq_ctrl;

  localparam logic [31:0] A_RAW     = 32'h00;
  localparam logic [31:0] A_PENDING = 32'h04;
  localparam logic [31:0] A_ENABLE  = 32'h08;
  localparam logic [31:0] A_MODE    = 32'h0C;
  localparam logic [31:0] A_CLAIM   = 32'h10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq;
  logic       irq_o;

  wb_irq_ctrl_if bus ();

  wb_irq_ctrl #(.NIRQ(4), .RST_MODE(4'h0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave),
    .irq_i (irq),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every ack pops one expected transaction; reads compare dat_o.
  always @(negedge clk) begin
    if (bus.ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 32'(bus.ack_o), 32'd0);
      end else begin
        exp_t t;
        t = sb.pop_front();
        if (t.is_rd) check(t.tag, bus.dat_o, t.exp);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 two edges later.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e, input string tag);
    exp_t t;
    t.is_rd = ~w;
    t.exp   = e;
    t.tag   = tag;
    sb.push_back(t);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = w;
    bus.adr_i = a;
    bus.dat_i = d;
    bus.sel_i = s;
    @(posedge clk);
    #1;
    check({tag, "_ack"}, 32'(bus.ack_o), 32'd1);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    if (bus.ack_o !== 1'b1) void'(sb.pop_back());
    @(posedge clk);
    #1;
    check({tag, "_ackdrop"}, 32'(bus.ack_o), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    xfer(1'b1, a, d, 4'hF, 32'd0, tag);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    xfer(1'b0, a, 32'd0, 4'hF, e, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    irq       = 4'h0;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = 32'd0;
    bus.dat_i = 32'd0;
    bus.sel_i = 4'h0;
    wait_cycles(3);
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_dat", bus.dat_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rst = 1'b0;

    // Reset values on every mapped offset
    rd(A_RAW,     32'h0, "rst_raw");
    rd(A_PENDING, 32'h0, "rst_pending");
    rd(A_ENABLE,  32'h0, "rst_enable");
    rd(A_MODE,    32'h0, "rst_mode");
    rd(A_CLAIM,   32'h0, "rst_claim");
    check("rst_irq_after", 32'(irq_o), 32'd0);

    // Edge pulse on source 2, claim clears it
    wr(A_ENABLE, 32'hF, "en_f");
    wr(A_MODE,   32'hF, "mode_f");
    irq = 4'h4;
    wait_cycles(1);
    irq = 4'h0;
    check("edge_irq_lat1", 32'(irq_o), 32'd0);
    wait_cycles(1);
    check("edge_irq_lat2", 32'(irq_o), 32'd1);
    rd(A_PENDING, 32'h4, "edge_pending");
    rd(A_CLAIM, 32'h8000_0002, "edge_claim");
    check("edge_irq_cleared", 32'(irq_o), 32'd0);
    rd(A_CLAIM, 32'h0, "edge_claim_empty");

    // Level mode ignores W1C while the source stays high
    wr(A_MODE,   32'h0, "mode_lvl");
    wr(A_ENABLE, 32'h1, "en_1");
    irq = 4'h1;
    wait_cycles(2);
    check("lvl_irq_on", 32'(irq_o), 32'd1);
    wr(A_PENDING, 32'h1, "lvl_w1c");
    rd(A_PENDING, 32'h1, "lvl_pending");
    rd(A_RAW, 32'h1, "lvl_raw");
    check("lvl_irq_held", 32'(irq_o), 32'd1);
    irq = 4'h0;
    wait_cycles(1);
    check("lvl_drop_lat1", 32'(irq_o), 32'd1);
    wait_cycles(1);
    check("lvl_drop_lat2", 32'(irq_o), 32'd0);

    // Priority claim among disabled and enabled pending sources
    wr(A_MODE,   32'hF, "mode_f2");
    wr(A_ENABLE, 32'hA, "en_a");
    irq = 4'hA;
    wait_cycles(1);
    irq = 4'h0;
    wait_cycles(1);
    check("prio_irq_on", 32'(irq_o), 32'd1);
    rd(A_CLAIM, 32'h8000_0001, "prio_claim1");
    rd(A_CLAIM, 32'h8000_0003, "prio_claim3");
    rd(A_CLAIM, 32'h0, "prio_claim_none");
    check("prio_irq_off", 32'(irq_o), 32'd0);
    irq = 4'h8;
    wait_cycles(1);
    irq = 4'h0;
    wr(A_ENABLE, 32'h0, "en_0");
    wait_cycles(1);
    check("masked_irq_off", 32'(irq_o), 32'd0);
    rd(A_PENDING, 32'h8, "masked_pending");
    wr(A_ENABLE, 32'h8, "en_8");
    check("late_enable_irq", 32'(irq_o), 32'd1);

    // Rise coinciding with W1C of the same bit keeps it pending
    wr(A_PENDING, 32'hF, "w1c_all");
    rd(A_PENDING, 32'h0, "w1c_all_pending");
    irq = 4'h2;
    wr(A_PENDING, 32'h2, "w1c_race");
    irq = 4'h0;
    rd(A_PENDING, 32'h2, "race_pending");

    // Byte lanes
    xfer(1'b1, A_ENABLE, 32'hFFFF_FFFF, 4'b0000, 32'd0, "sel_none");
    rd(A_ENABLE, 32'h8, "sel_none_enable");
    xfer(1'b1, A_ENABLE, 32'h0000_0105, 4'b0010, 32'd0, "sel_lane1");
    rd(A_ENABLE, 32'h8, "sel_lane1_enable");
    xfer(1'b1, A_ENABLE, 32'h0000_0105, 4'b0001, 32'd0, "sel_lane0");
    rd(A_ENABLE, 32'h5, "sel_lane0_enable");
    xfer(1'b1, A_PENDING, 32'h2, 4'b0000, 32'd0, "sel_w1c_none");
    rd(A_PENDING, 32'h2, "sel_w1c_pending");

    // Unmapped offsets
    rd(32'h14, 32'h0, "unmapped_14");
    rd(32'h1C, 32'h0, "unmapped_1c");
    wr(32'h18, 32'hF, "unmapped_wr");
    rd(A_ENABLE, 32'h5, "unmapped_enable");
    rd(A_MODE,   32'hF, "unmapped_mode");

    // Reset during the request cycle of a write
    wr(A_ENABLE, 32'hF, "en_f_pre_rst");
    check("pre_rst_irq", 32'(irq_o), 32'd1);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = A_ENABLE;
    bus.dat_i = 32'hF;
    bus.sel_i = 4'hF;
    rst       = 1'b1;
    wait_cycles(1);
    check("midrst_ack", 32'(bus.ack_o), 32'd0);
    check("midrst_irq", 32'(irq_o), 32'd0);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    rst       = 1'b0;
    wait_cycles(1);
    check("midrst_ack2", 32'(bus.ack_o), 32'd0);
    rd(A_ENABLE,  32'h0, "midrst_enable");
    rd(A_PENDING, 32'h0, "midrst_pending");
    rd(A_MODE,    32'h0, "midrst_mode");

    wait_cycles(2);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
